down_count_timer: RTL



---
 rtl/dct_pkg.sv | 18 +
 rtl/dct_prescaler.sv | 40 ++++
 rtl/down_count_timer.sv | 105 ++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared types and defaults for the loadable down-count timer.
// Optional prescaler is enabled with the DCT_PRESCALE_EN macro.
package dct_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } dct_state_e;

  localparam int DCT_WIDTH    = 4;
  localparam int DCT_PRESCALE = 4;

  function automatic int dct_cnt_w(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/dct_prescaler.sv
// Tick generator: one tick every PRESCALE enabled cycles.
// Built only when DCT_PRESCALE_EN is defined.
module dct_prescaler
  import dct_pkg::*;
#(
  parameter int PRESCALE = DCT_PRESCALE
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = dct_cnt_w(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/down_count_timer.sv
// Loadable down-counter/timer with one-shot or auto-reload mode.
// Define DCT_PRESCALE_EN to divide the count tick by PRESCALE.
module down_count_timer
  import dct_pkg::*;
#(
  parameter int WIDTH    = DCT_WIDTH,
  parameter int PRESCALE = DCT_PRESCALE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  input  logic             en,
  input  logic             stop,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             expired,
  output logic             tc_pulse
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  generate
    if (PRESCALE < 1) begin : g_bad_prescale
      $error("PRESCALE must be >= 1");
    end
  endgenerate

  dct_state_e       state_q;
  dct_state_e       state_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] reload_q;
  logic [WIDTH-1:0] reload_d;
  logic             mode_q;
  logic             mode_d;
  logic             tc_q;
  logic             tc_d;
  logic             tick;

`ifdef DCT_PRESCALE_EN
  dct_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .clr    (load | stop),
    .en_i   (en && (state_q == RUN)),
    .tick_o (tick)
  );
`else
  assign tick = en;
`endif

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    tc_d     = 1'b0;
    if (load) begin
      q_d      = load_val;
      reload_d = load_val;
      mode_d   = auto_reload;
      state_d  = (load_val != '0) ? RUN : IDLE;
    end else if (stop) begin
      state_d = IDLE;
    end else if ((state_q == RUN) && tick) begin
      if (q_q > ONE) begin
        q_d = q_q - ONE;
      end else if (mode_q) begin
        q_d  = reload_q;
        tc_d = 1'b1;
      end else begin
        // terminal count; q parks at zero, never wraps
        q_d     = '0;
        state_d = EXPIRED;
        tc_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      q_q      <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      tc_q     <= tc_d;
    end
  end

  assign q        = q_q;
  assign busy     = (state_q == RUN);
  assign expired  = (state_q == EXPIRED);
  assign tc_pulse = tc_q;

endmodule
